// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state types and the byte-layout helper.
//   state_t  : 128-bit AES state, byte k = state[8k+7:8k]
//   byte_t   : one state byte
//   NB       : number of state columns (4)
//   NR_ROWS  : number of state rows (4)
//   byte_idx : flat byte index of (row, col) for a given layout
//              (row_major=1: row*NB+col, row_major=0: col*NR_ROWS+row)
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam int NB      = 4;
  localparam int NR_ROWS = 4;

  function automatic int byte_idx(input int row, input int col, input int row_major);
    if (row_major != 0) begin
      return row * NB + col;
    end else begin
      return col * NR_ROWS + row;
    end
  endfunction

endpackage

// File: rtl/shift_rows_1_perm.sv
// shift_rows_1_perm: combinational AES ShiftRows / InvShiftRows byte rewiring.
//   Parameter ROW_MAJOR : 1 = byte k at (k/4, k%4), 0 = byte k at (k%4, k/4)
//   state  (in)  : 128-bit input state
//   inv    (in)  : 1 = InvShiftRows (rotate row r right by r), 0 = forward
//   result (out) : permuted state, same byte layout as state
module shift_rows_1_perm
  import aes_pkg::*;
#(
  parameter int ROW_MAJOR = 1
) (
  input  logic [127:0] state,
  input  logic         inv,
  output logic [127:0] result
);

  // One destination byte per iteration; the source column depends on the
  // direction, so each output byte is a 2:1 mux of two fixed input bytes.
  genvar gi;
  generate
    for (gi = 0; gi < NB * NR_ROWS; gi = gi + 1) begin : g_byte
      localparam int ROW     = (ROW_MAJOR != 0) ? (gi / NB) : (gi % NR_ROWS);
      localparam int COL     = (ROW_MAJOR != 0) ? (gi % NB) : (gi / NR_ROWS);
      localparam int SRC_FWD = byte_idx(ROW, (COL + ROW) % NB, ROW_MAJOR);
      localparam int SRC_INV = byte_idx(ROW, (COL - ROW + NB) % NB, ROW_MAJOR);

      assign result[8*gi +: 8] = inv ? state[8*SRC_INV +: 8] : state[8*SRC_FWD +: 8];
    end
  endgenerate

endmodule

// File: rtl/shift_rows_1.sv
// shift_rows_1: registered AES ShiftRows stage (1-cycle latency).
//   Parameter ROW_MAJOR : state byte layout (1 = row-major, 0 = FIPS column-major)
//   Optional macro SHIFT_ROWS_INV_EN adds the inv port (InvShiftRows select).
//   clk       (in)  : rising-edge clock
//   rst       (in)  : synchronous active-high reset, priority over in_valid
//   inv       (in)  : [SHIFT_ROWS_INV_EN only] 1 = inverse, 0 = forward
//   in_valid  (in)  : qualifies in
//   in        (in)  : input state, byte k = in[8k+7:8k]
//   out_valid (out) : out holds a state computed on the previous edge
//   out       (out) : shifted state, held while in_valid=0
module shift_rows_1
  import aes_pkg::*;
#(
  parameter int ROW_MAJOR = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef SHIFT_ROWS_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  input  logic [127:0] in,
  output logic         out_valid,
  output logic [127:0] out
);

  state_t perm_next;
  state_t out_reg;
  logic   out_valid_reg;
  logic   inv_sel;

`ifdef SHIFT_ROWS_INV_EN
  assign inv_sel = inv;
`else
  assign inv_sel = 1'b0;
`endif

  shift_rows_1_perm #(
    .ROW_MAJOR (ROW_MAJOR)
  ) u_perm (
    .state  (in),
    .inv    (inv_sel),
    .result (perm_next)
  );

  // The data register only loads on in_valid, so garbage on in during idle
  // cycles never reaches out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        out_reg <= perm_next;
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_shift_rows_1.sv
// tb_shift_rows_1: directed and identity checks of shift_rows_1 in both
// byte layouts (dut1: ROW_MAJOR=1, dut0: ROW_MAJOR=0).
module tb_shift_rows_1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in;
  logic         out_valid1, out_valid0;
  logic [127:0] out1, out0;
`ifdef SHIFT_ROWS_INV_EN
  logic         inv;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [127:0] S1      = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [127:0] EXP_RM1 = 128'heeddccff_9988bbaa_44776655_33221100;
  localparam logic [127:0] EXP_RM0 = 128'hbb6611cc_7722dd88_33ee9944_ffaa5500;
  localparam logic [127:0] EXP_FF  = {128{1'b1}};
  localparam logic [127:0] EXP_TWICE = 128'hddccffee_bbaa9988_55447766_33221100;

  always #5 clk = ~clk;

  shift_rows_1 #(.ROW_MAJOR(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
`ifdef SHIFT_ROWS_INV_EN
    .inv       (inv),
`endif
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid1),
    .out       (out1)
  );

  shift_rows_1 #(.ROW_MAJOR(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
`ifdef SHIFT_ROWS_INV_EN
    .inv       (inv),
`endif
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid0),
    .out       (out0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic r, input logic v, input logic [127:0] d);
    rst      = r;
    in_valid = v;
    in       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] orig, cur;
`ifdef SHIFT_ROWS_INV_EN
    inv = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; in = '0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, '0);
    check("reset_out", out1, '0);
    check("reset_valid", {127'd0, out_valid1}, 128'd0);

    // Scenarios 1 and 2: one valid transfer, both layouts.
    step(1'b0, 1'b1, S1);
    check("rm1_valid", {127'd0, out_valid1}, 128'd1);
    check("rm1_out", out1, EXP_RM1);
    check("rm0_valid", {127'd0, out_valid0}, 128'd1);
    check("rm0_out", out0, EXP_RM0);
    $display("txn scenario1/2: in=%h out1=%h out0=%h", S1, out1, out0);

    // Reset with a transfer in the same cycle: transfer is dropped.
    step(1'b1, 1'b1, S1);
    check("rst_drop_out", out1, '0);
    check("rst_drop_valid", {127'd0, out_valid1}, 128'd0);
    check("rst_drop_out0", out0, '0);
    step(1'b0, 1'b1, S1);
    check("post_rst_valid", {127'd0, out_valid1}, 128'd1);
    check("post_rst_out", out1, EXP_RM1);
    $display("txn reset-recover: out1=%h", out1);

    // Streaming three back-to-back states, then hold.
    step(1'b0, 1'b1, '0);
    check("stream0_valid", {127'd0, out_valid1}, 128'd1);
    check("stream0_out", out1, '0);
    step(1'b0, 1'b1, S1);
    check("stream1_valid", {127'd0, out_valid1}, 128'd1);
    check("stream1_out", out1, EXP_RM1);
    check("stream1_out0", out0, EXP_RM0);
    step(1'b0, 1'b1, EXP_FF);
    check("stream2_valid", {127'd0, out_valid1}, 128'd1);
    check("stream2_out", out1, EXP_FF);
    step(1'b0, 1'b0, 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978);
    check("hold_valid", {127'd0, out_valid1}, 128'd0);
    check("hold_out", out1, EXP_FF);
    step(1'b0, 1'b0, 'x);
    check("hold_x_out", out1, EXP_FF);
    check("hold_x_out0", out0, EXP_FF);
    $display("txn stream/hold: out1=%h valid=%0d", out1, out_valid1);

`ifdef SHIFT_ROWS_INV_EN
    inv = 1'b1;
    step(1'b0, 1'b1, EXP_RM1);
    check("inv_recover", out1, S1);
    inv = 1'b0;
    step(1'b0, 1'b1, EXP_RM1);
    check("inv0_forward", out1, EXP_TWICE);
    $display("txn inv: out1=%h", out1);
`else
    step(1'b0, 1'b1, EXP_RM1);
    check("forward_twice", out1, EXP_TWICE);
    $display("txn forward-twice: out1=%h", out1);
`endif

    // Four forward passes return the original state, both layouts.
    for (int t = 0; t < 1000; t++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      cur  = orig;
      for (int p = 0; p < 4; p++) begin
        step(1'b0, 1'b1, cur);
        cur = out1;
      end
      check("identity4_rm1", cur, orig);
      cur = orig;
      for (int p = 0; p < 4; p++) begin
        step(1'b0, 1'b1, cur);
        cur = out0;
      end
      check("identity4_rm0", cur, orig);
      if (t % 100 == 0) $display("txn identity %0d: state=%h", t, orig);
    end
    step(1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/shift_rows_1.md
Name: shift_rows_1

Overview:
Registered AES ShiftRows stage on a 128-bit state. It sits in the AES round datapath between SubBytes and MixColumns. Each accepted state is permuted by cyclic left-rotation of row r by r byte positions. The result is presented one clock later with a valid flag.

Parameters:
ROW_MAJOR, 1, state byte layout:
- 1: byte k = in[8k+7:8k] sits at row k/4, column k%4.
- 0: FIPS-197 column-major layout, byte k at row k%4, column k/4.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  qualifies in for this cycle
in  input  128  input state; byte k = in[8k+7:8k]
out_valid  output  1  out holds a freshly computed state
out  output  128  shifted state; same byte layout as in

Behaviour:
- Notation: S(r,c) is the state byte at row r, column c.
- Permutation (forward): out S(r,c) = in S(r,(c+r) mod 4), for r,c in 0..3.
  - Row 0 is unchanged.
  - Row 1 rotates left 1, row 2 rotates left 2, row 3 rotates left 3.
- The permutation is pure byte rewiring: no arithmetic, no width change, bytes moved intact.
- Latency is exactly 1 cycle. On a clk edge with in_valid=1:
  - out <= perm(in)
  - out_valid <= 1
- On a clk edge with in_valid=0:
  - out holds its previous value.
  - out_valid <= 0.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure and no ready signal.
- Reset: on a clk edge with rst=1, out <= 128'h0 and out_valid <= 0.
  - rst has priority over in_valid.
  - A transfer presented in the same cycle as rst is dropped.
- rst asserted mid-stream clears the pipeline register. The first valid output after reset deassertion appears one cycle after the first in_valid=1.
- X on in while in_valid=0 must not propagate to out.
- Applying the forward permutation four times returns the original state (self-check identity).

Optional Feature:
Macro SHIFT_ROWS_INV_EN.
- Defined:
  - Adds input port inv (1 bit), sampled together with in when in_valid=1.
  - inv=1 performs InvShiftRows: out S(r,c) = in S(r,(c-r) mod 4), i.e. right rotation by r.
  - inv=0 performs forward ShiftRows.
  - Latency, reset and valid behaviour are unchanged.
- Not defined: no inv port; forward only.

Decomposition:
- Package aes_pkg:
  - state_t (128-bit vector) and byte_t (8-bit).
  - Constants NB=4 and NR_ROWS=4.
  - Function byte_idx(row, col, row_major) returning the flat byte index.
- One combinational sub-module, shift_rows_1_perm:
  - Pure permutation taking state, inv and ROW_MAJOR.
  - The top module adds only the valid register and the output register.

Test Plan:
1. ROW_MAJOR=1; in bytes 0..15 = 00,11,22,...,ff; in_valid=1 for one cycle. Next cycle: out_valid=1 and out rows are:
   - 00 11 22 33
   - 55 66 77 44
   - aa bb 88 99
   - ff cc dd ee
2. ROW_MAJOR=0, same input. Out bytes 0..15 = 00 55 aa ff 44 99 ee 33 88 dd 22 77 cc 11 66 bb.
3. Reset:
   - rst=1 with in_valid=1 -> next cycle out=0, out_valid=0.
   - Release rst, apply the scenario 1 input -> the scenario 1 result appears one cycle later.
4. Streaming and hold:
   - Three consecutive valid states (all-zero, scenario 1 state, all-ff) -> outputs appear on three consecutive cycles with out_valid=1 throughout.
   - Then in_valid=0 -> out_valid=0 and out holds the all-ff result.
5. SHIFT_ROWS_INV_EN, ROW_MAJOR=1:
   - Feed the scenario 1 output with inv=1 -> the original 00,11,...,ff is recovered.
   - inv=0 on the same input -> the forward result is produced.
6. Randomized: 1000 random states, each fed four times through forward mode -> identical to the original state.
